// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider (DIV: quotient to lo, remainder to hi)
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high; aborts any operation in progress
//   start     request pulse, sampled only while idle
//   dividend  signed dividend, sampled with start
//   divisor   signed divisor, sampled with start
//   hi        remainder (sign of dividend), registered
//   lo        quotient (truncated toward zero), registered
//   busy      high from the accepting edge until the fix-up edge
//   done      one-cycle pulse, hi/lo freshly valid
//   div0      one-cycle pulse, divisor was zero (hi/lo untouched)

module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_ZDIV = 3'd4;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;      // dividend, then its magnitude, then the quotient
    logic [WIDTH-1:0] r_b;      // divisor, then its magnitude
    logic [WIDTH-1:0] r_rem;
    logic             r_sq;
    logic             r_sr;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;

    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    // Magnitudes are unsigned, so -(-2^(WIDTH-1)) wrapping to itself is the
    // correct magnitude 2^(WIDTH-1).
    assign w_a_abs = r_q[WIDTH-1] ? (~r_q + 1'b1) : r_q;
    assign w_b_abs = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

    // rem < |divisor| <= 2^(WIDTH-1), so the shifted partial remainder fits in
    // WIDTH+1 bits and a negative trial shows up in the top bit.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_b};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_q     <= dividend;
                            r_b     <= divisor;
                            r_sq    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sr    <= dividend[WIDTH-1];
                            r_busy  <= 1'b1;
                            r_state <= S_PREP;
                        end else begin
                            r_state <= S_ZDIV;
                        end
                    end
                end
                S_PREP: begin
                    r_q     <= w_a_abs;
                    r_b     <= w_b_abs;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_sq ? (~r_q + 1'b1) : r_q;
                    r_hi    <= r_sr ? (~r_rem + 1'b1) : r_rem;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ZDIV: begin
                    r_div0  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;

endmodule
